// File: rtl/fir_out_requant_fifo.sv
// Requantizer behind the FIR: rounds/saturates 32b accum to 16b, counts
// sat/drop events, buffers samples in a show-ahead FIFO with valid/ready.
// Ports: clk, reset (sync, active-low), in_data/in_valid (FIR side),
//   out_data/out_valid/out_ready (consumer side), level, overflow,
//   sat_cnt, drop_cnt, clr_stats.
module fir_out_requant_fifo #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 16,
  parameter int SHIFT = 15,
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic signed [IN_W-1:0]      in_data,
  input  logic                        in_valid,
  output logic signed [OUT_W-1:0]     out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [$clog2(DEPTH):0]      level,
  output logic                        overflow,
  output logic [CNT_W-1:0]            sat_cnt,
  output logic [CNT_W-1:0]            drop_cnt,
  input  logic                        clr_stats
);

  localparam int AW  = $clog2(DEPTH);
  localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam int PAD = IN_W - OUT_W + 2;

  localparam logic signed [IN_W:0] RND =
    (SHIFT > 0) ? ((IN_W+1)'(1) << RSH) : '0;
  localparam logic signed [IN_W:0] SMAX =
    {{PAD{1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W:0] SMIN =
    {{PAD{1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0] OMAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] OMIN = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [AW:0] LFULL = (AW+1)'(DEPTH);

  logic signed [IN_W:0] ext;
  logic signed [IN_W:0] rnd;
  logic signed [IN_W:0] shf;
  logic                 sat_hi;
  logic                 sat_lo;
  logic [OUT_W-1:0]     clamped;

  // One extra bit of headroom so the rounding add can't wrap.
  assign ext     = {in_data[IN_W-1], in_data};
  assign rnd     = ext + RND;
  assign shf     = rnd >>> SHIFT;
  assign sat_hi  = shf > SMAX;
  assign sat_lo  = shf < SMIN;
  assign clamped = sat_hi ? OMAX :
                   sat_lo ? OMIN : shf[OUT_W-1:0];

  logic             s1_valid;
  logic             s1_sat;
  logic [OUT_W-1:0] s1_data;

  logic [OUT_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             full;
  logic             rd;
  logic             wr;
  logic             drop;

  assign out_valid = level != '0;
  assign full      = level == LFULL;
  assign rd        = out_valid & out_ready;
  // Full FIFO still accepts when the head leaves this same cycle.
  assign wr        = s1_valid & (~full | rd);
  assign drop      = s1_valid & full & ~rd;
  assign out_data  = out_valid ? mem[rptr] : '0;

  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= s1_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_sat   <= 1'b0;
      s1_data  <= '0;
      wptr     <= '0;
      rptr     <= '0;
      level    <= '0;
      overflow <= 1'b0;
      sat_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_data <= clamped;
        s1_sat  <= sat_hi | sat_lo;
      end
      if (wr) wptr <= wptr + 1'b1;
      if (rd) rptr <= rptr + 1'b1;
      level <= level + {{AW{1'b0}}, wr} - {{AW{1'b0}}, rd};
      if (clr_stats) begin
        overflow <= 1'b0;
        sat_cnt  <= '0;
        drop_cnt <= '0;
      end else begin
        if (drop) overflow <= 1'b1;
        if (drop && drop_cnt != '1)
          drop_cnt <= drop_cnt + 1'b1;
        if (s1_valid && s1_sat && sat_cnt != '1)
          sat_cnt <= sat_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fir_out_requant_fifo.sv
// Bench for fir_out_requant_fifo: queue-based reference model checked
// every cycle, directed scenarios plus randomized traffic.
module tb_fir_out_requant_fifo;

  localparam int DEPTH = 8;
  localparam int CMAX  = 65535;

  logic               clk;
  logic               reset;
  logic signed [31:0] in_data;
  logic               in_valid;
  logic signed [15:0] out_data;
  logic               out_valid;
  logic               out_ready;
  logic [3:0]         level;
  logic               overflow;
  logic [15:0]        sat_cnt;
  logic [15:0]        drop_cnt;
  logic               clr_stats;

  fir_out_requant_fifo dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level),
    .overflow  (overflow),
    .sat_cnt   (sat_cnt),
    .drop_cnt  (drop_cnt),
    .clr_stats (clr_stats)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 0;

  task automatic chk(string nm, logic signed [63:0] act,
                     logic signed [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Round half up, shift by 15, clamp to int16, using plain integers.
  function automatic int rescale(input logic [31:0] d, output bit sat);
    longint v;
    v = longint'($signed(d));
    v = v + 16384;
    v = v >>> 15;
    sat = 1'b0;
    if (v > 32767) begin v = 32767; sat = 1'b1; end
    if (v < -32768) begin v = -32768; sat = 1'b1; end
    return int'(v);
  endfunction

  int q[$];
  bit m_s1v  = 0;
  int m_s1d  = 0;
  bit m_s1s  = 0;
  bit m_ovf  = 0;
  int m_sat  = 0;
  int m_drop = 0;

  always @(posedge clk) begin
    bit do_rd;
    if (!reset) begin
      q.delete();
      m_s1v = 0; m_ovf = 0; m_sat = 0; m_drop = 0;
    end else begin
      do_rd = (q.size() > 0) && out_ready;
      if (do_rd) void'(q.pop_front());
      if (m_s1v) begin
        if (q.size() < DEPTH) q.push_back(m_s1d);
        else begin
          m_ovf = 1;
          if (m_drop < CMAX) m_drop++;
        end
        if (m_s1s && m_sat < CMAX) m_sat++;
      end
      if (clr_stats) begin
        m_ovf = 0; m_sat = 0; m_drop = 0;
      end
      m_s1v = in_valid;
      if (in_valid) m_s1d = rescale(in_data, m_s1s);
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("out_valid", out_valid, q.size() != 0);
      chk("out_data", out_data, (q.size() != 0) ? q[0] : 0);
      chk("level", level, q.size());
      chk("overflow", overflow, m_ovf);
      chk("sat_cnt", sat_cnt, m_sat);
      chk("drop_cnt", drop_cnt, m_drop);
    end
  end

  task automatic drive(bit v, logic [31:0] d, bit r, bit c);
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    clr_stats = c;
  endtask

  function automatic logic [31:0] rnd_data();
    logic [31:0] d;
    case ($urandom_range(0, 3))
      0: d = $urandom;
      1: d = 32'(int'($urandom_range(0, 200000)) - 100000);
      2: d = $urandom_range(0, 1) ?
           32'(1073725440 + int'($urandom_range(0, 8)) - 4) :
           32'(-1073758208 + int'($urandom_range(0, 8)) - 4);
      default: d = 32'(16384 * (int'($urandom_range(0, 64)) - 32) +
                       int'($urandom_range(0, 2)) - 1);
    endcase
    return d;
  endfunction

  initial begin
    bit s;
    int r;
    reset = 0; in_valid = 0; in_data = 0;
    out_ready = 0; clr_stats = 0;

    r = rescale(32'd32768, s);       chk("pin_imp", r, 1);
    r = rescale(32'd16383, s);       chk("pin_r16383", r, 0);
    r = rescale(-32'sd16385, s);     chk("pin_rm16385", r, -1);
    r = rescale(32'd49152, s);       chk("pin_r49152", r, 2);
    r = rescale(32'h7FFFFFFF, s);    chk("pin_smax", r, 32767);
    chk("pin_smax_sat", s, 1);
    r = rescale(32'h80000000, s);    chk("pin_smin", r, -32768);

    @(negedge clk);
    @(negedge clk);
    chk_on = 1;
    reset  = 1;

    // impulse
    drive(1, 32768, 0, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 1, 0);
    chk("imp_valid", out_valid, 1);
    chk("imp_data", out_data, 1);
    chk("imp_level", level, 1);
    drive(0, 0, 0, 0);
    chk("imp_empty", level, 0);

    // rounding
    drive(1, 16384, 0, 0);
    drive(1, 16383, 0, 0);
    drive(1, -32'sd16384, 0, 0);
    drive(1, -32'sd16385, 0, 0);
    drive(1, 49152, 0, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    chk("rnd_head", out_data, 1);
    chk("rnd_sat", sat_cnt, 0);
    repeat (6) drive(0, 0, 1, 0);

    // saturation
    drive(1, 32'h7FFFFFFF, 0, 0);
    drive(1, 32'h80000000, 0, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    chk("sat_head", out_data, 32767);
    chk("sat_cnt2", sat_cnt, 2);
    chk("sat_ovf", overflow, 0);
    repeat (3) drive(0, 0, 1, 0);

    // backpressure
    for (int k = 1; k <= 10; k++) drive(1, 32768 * k, 0, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    chk("bp_level", level, 8);
    chk("bp_drop", drop_cnt, 2);
    chk("bp_ovf", overflow, 1);
    for (int k = 1; k <= 8; k++) begin
      drive(0, 0, 1, 0);
      chk("bp_order", out_data, k);
    end
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 0);
    chk("clr_ovf", overflow, 0);
    chk("clr_drop", drop_cnt, 0);
    chk("clr_sat", sat_cnt, 0);

    // full with simultaneous read/write
    for (int k = 1; k <= 20; k++) begin
      drive(1, 32768 * k, k >= 10, 0);
      if (k >= 10) chk("rw_level", level, 8);
    end
    repeat (12) drive(0, 0, 1, 0);
    chk("rw_drop", drop_cnt, 0);

    // reset mid-stream
    for (int k = 1; k <= 6; k++) drive(1, 32768 * k, 0, 0);
    drive(1, 32'h7FFFFFFF, 0, 0);
    chk("pre_rst_level", level, 5);
    @(negedge clk);
    reset = 0; in_valid = 0;
    @(negedge clk);
    reset = 1;
    chk("rst_level", level, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_sat", sat_cnt, 0);
    drive(1, 32768, 0, 0);
    drive(0, 0, 0, 0);
    chk("rst_lat1", out_valid, 0);
    drive(0, 0, 1, 0);
    chk("rst_lat2", out_valid, 1);
    chk("rst_data", out_data, 1);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 99) < 70, rnd_data(),
            $urandom_range(0, 99) < ((i % 400 < 200) ? 25 : 85),
            $urandom_range(0, 99) == 0);
      reset = ($urandom_range(0, 299) != 0);
    end
    reset = 1;
    repeat (12) drive(0, 0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
